// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming target host-side driver.
package hamming_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_MODE,
    S_DATA,
    S_WAIT,
    S_CAP1,
    S_CAP2,
    S_RESP
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [7:0] START_BYTE = 8'h01;

  localparam int SYN_MSB = 4;
  localparam int SYN_LSB = 2;
  localparam int ERR_MSB = 1;
  localparam int ERR_LSB = 0;

endpackage

// File: rtl/hamming_rsp_unpack.sv
// Splits the two captured response bytes into syndrome, error and format-check fields.
// Purely combinational: zero latency, no flow control.
module hamming_rsp_unpack
  import hamming_pkg::*;
(
  input  logic       mode,
  input  logic [7:0] word0,
  input  logic [7:0] word1,
  output logic [2:0] syndrome,
  output logic [1:0] err,
  output logic       fmt_err
);

  always_comb begin
    syndrome = '0;
    err      = '0;
    fmt_err  = 1'b0;
    if (mode == MODE_DEC) begin
      syndrome = word1[SYN_MSB:SYN_LSB];
      err      = word1[ERR_MSB:ERR_LSB];
      fmt_err  = |word1[7:SYN_MSB+1];
    end else begin
      // The target echoes the codeword in both response bytes.
      fmt_err = (word0 != word1);
    end
  end

endmodule

// File: rtl/hamming_host_driver.sv
// Byte-serial initiator for the Hamming target: sends start/mode/data, captures two response bytes.
// rsp_valid rises 6+IO_LAT edges after acceptance; the response is held until rsp_ready.
module hamming_host_driver
  import hamming_pkg::*;
#(
  parameter int IO_LAT  = 0,
  parameter int MIN_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_mode,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_mode,
  output logic [7:0] rsp_word0,
  output logic [7:0] rsp_word1,
  output logic [2:0] rsp_syndrome,
  output logic [1:0] rsp_err,
  output logic       rsp_fmt_err,
  output logic [7:0] tgt_bus_out,
  input  logic [7:0] tgt_rsp_in,
  output logic       busy
);

  localparam int WAIT_W = (IO_LAT > 0) ? $clog2(IO_LAT + 1) : 1;
  localparam int GAP_W  = $clog2(MIN_GAP + 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              mode_q;
  logic [7:0]        data_q;
  logic [7:0]        word0_q;
  logic [7:0]        word1_q;
  logic [7:0]        bus_nxt;
  logic              accept;

  // Gap counter resets to zero, so the driver is ready as soon as reset releases.
  assign req_ready = (state == S_IDLE) && (gap_cnt == '0) && !rst;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_mode  = mode_q;
  assign rsp_word0 = word0_q;
  assign rsp_word1 = word1_q;

  always_comb begin
    state_nxt = state;
    bus_nxt   = 8'h00;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_START;
      S_START: state_nxt = S_MODE;
      S_MODE:  state_nxt = S_DATA;
      S_DATA:  state_nxt = S_WAIT;
      S_WAIT:  if (wait_cnt == WAIT_W'(IO_LAT)) state_nxt = S_CAP1;
      S_CAP1:  state_nxt = S_CAP2;
      S_CAP2:  state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // The bus flop is loaded with the byte belonging to the state being entered.
    case (state_nxt)
      S_START: bus_nxt = START_BYTE;
      S_MODE:  bus_nxt = {7'b0, mode_q};
      S_DATA:  bus_nxt = (mode_q == MODE_DEC) ? data_q : {4'b0, data_q[3:0]};
      default: bus_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      tgt_bus_out <= 8'h00;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      mode_q      <= 1'b0;
      data_q      <= 8'h00;
      word0_q     <= 8'h00;
      word1_q     <= 8'h00;
    end else begin
      state       <= state_nxt;
      tgt_bus_out <= bus_nxt;
      wait_cnt    <= (state == S_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      if (accept) begin
        mode_q <= req_mode;
        data_q <= req_data;
      end
      if (state == S_CAP1) word0_q <= tgt_rsp_in;
      if (state == S_CAP2) word1_q <= tgt_rsp_in;
      if (state_nxt == S_RESP && state != S_RESP) begin
        gap_cnt <= GAP_W'(MIN_GAP);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  hamming_rsp_unpack u_unpack (
    .mode     (mode_q),
    .word0    (word0_q),
    .word1    (word1_q),
    .syndrome (rsp_syndrome),
    .err      (rsp_err),
    .fmt_err  (rsp_fmt_err)
  );

endmodule
